// File: rtl/pwm_meas_pkg.sv
// rtl/pwm_meas_pkg.sv - shared state type and sizing constants for pulse_width_meter
package pwm_meas_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    MEASURE = 2'b01,
    HOLD    = 2'b10
  } pwm_state_t;

  localparam int PWM_CNT_W_DEF = 16;
  localparam int PWM_DROP_W    = 8;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - unsigned counter with clear, load-one and saturating increment
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load1,
  input  logic         inc,
  output logic [W-1:0] value,
  output logic         at_max
);

  assign at_max = &value;

  // clear beats load beats increment; increment stalls at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (load1) begin
      value <= W'(1);
    end else if (inc && !at_max) begin
      value <= value + W'(1);
    end
  end

endmodule

// File: rtl/pulse_width_meter.sv
// rtl/pulse_width_meter.sv - measures high periods from rise/fall strobes, valid/ready result
// Optional drop counter enabled by PWM_DROP_CNT_EN.
module pulse_width_meter
  import pwm_meas_pkg::*;
#(
  parameter int CNT_W = PWM_CNT_W_DEF
) (
  input  logic             clk_fast,
  input  logic             rst_n,
  input  logic             rise_pulse,
  input  logic             fall_pulse,
  input  logic             meas_ready,
  output logic             meas_valid,
  output logic [CNT_W-1:0] meas_width,
  output logic             meas_sat,
  output logic             busy
`ifdef PWM_DROP_CNT_EN
  ,
  output logic [PWM_DROP_W-1:0] drop_cnt
`endif
);

  pwm_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             cnt_max;
  logic             sat_q;
  logic             cnt_load;
  logic             cnt_inc;
  logic             cnt_clr;

  // a handshake with a coincident rise restarts immediately, no dead cycle
  assign cnt_load = ((state == IDLE) && rise_pulse && !fall_pulse) ||
                    ((state == HOLD) && meas_ready && rise_pulse);
  assign cnt_inc  = (state == MEASURE) && !fall_pulse;
  assign cnt_clr  = (state == HOLD) && meas_ready && !rise_pulse;

  sat_counter #(.W(CNT_W)) u_width_cnt (
    .clk    (clk_fast),
    .rst_n  (rst_n),
    .clr    (cnt_clr),
    .load1  (cnt_load),
    .inc    (cnt_inc),
    .value  (cnt),
    .at_max (cnt_max)
  );

  always_ff @(posedge clk_fast or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sat_q      <= 1'b0;
      meas_width <= '0;
      meas_sat   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rise_pulse && !fall_pulse) begin
            state <= MEASURE;
            sat_q <= 1'b0;
          end
        end
        MEASURE: begin
          if (fall_pulse) begin
            meas_width <= cnt;
            meas_sat   <= sat_q;
            state      <= HOLD;
          end else if (cnt_max) begin
            sat_q <= 1'b1;
          end
        end
        HOLD: begin
          if (meas_ready) begin
            if (rise_pulse) begin
              state <= MEASURE;
              sat_q <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign meas_valid = (state == HOLD);
  assign busy       = (state != IDLE);

`ifdef PWM_DROP_CNT_EN
  logic drop_evt;
  logic drop_max;

  assign drop_evt = (state == HOLD) && !meas_ready && rise_pulse;

  sat_counter #(.W(PWM_DROP_W)) u_drop_cnt (
    .clk    (clk_fast),
    .rst_n  (rst_n),
    .clr    (1'b0),
    .load1  (1'b0),
    .inc    (drop_evt && !drop_max),
    .value  (drop_cnt),
    .at_max (drop_max)
  );
`endif

endmodule

// File: tb/tb_pulse_width_meter.sv
// tb/tb_pulse_width_meter.sv - scoreboard bench for pulse_width_meter (main and CNT_W=4 instances)
module tb_pulse_width_meter;

  typedef struct {
    logic [31:0] width;
    logic        sat;
  } exp_t;

  logic        clk_fast = 1'b0;
  logic        rst_n = 1'b0;
  logic        rise_pulse = 1'b0, fall_pulse = 1'b0, meas_ready = 1'b1;
  logic        meas_valid, meas_sat, busy;
  logic [15:0] meas_width;

  logic        rise_s = 1'b0, fall_s = 1'b0;
  logic        valid_s, sat_s, busy_s;
  logic [3:0]  width_s;

  int vectors = 0;
  int miscompares = 0;
  exp_t exp_q[$];
  exp_t exp_s_q[$];

`ifdef PWM_DROP_CNT_EN
  logic [7:0] drop_cnt, drop_s;
`endif

  always #5 clk_fast = ~clk_fast;

  pulse_width_meter #(.CNT_W(16)) dut (
    .clk_fast   (clk_fast),
    .rst_n      (rst_n),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .meas_ready (meas_ready),
    .meas_valid (meas_valid),
    .meas_width (meas_width),
    .meas_sat   (meas_sat),
    .busy       (busy)
`ifdef PWM_DROP_CNT_EN
    , .drop_cnt (drop_cnt)
`endif
  );

  pulse_width_meter #(.CNT_W(4)) dut_sat (
    .clk_fast   (clk_fast),
    .rst_n      (rst_n),
    .rise_pulse (rise_s),
    .fall_pulse (fall_s),
    .meas_ready (1'b1),
    .meas_valid (valid_s),
    .meas_width (width_s),
    .meas_sat   (sat_s),
    .busy       (busy_s)
`ifdef PWM_DROP_CNT_EN
    , .drop_cnt (drop_s)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_fast);
    #1;
  endtask

  always @(negedge clk_fast) begin
    if (rst_n && meas_valid && meas_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 32'(meas_width), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("width", 32'(meas_width), e.width);
        chk("sat", 32'(meas_sat), 32'(e.sat));
      end
    end
  end

  always @(negedge clk_fast) begin
    if (rst_n && valid_s) begin
      if (exp_s_q.size() == 0) begin
        chk("unexpected_result_w4", 32'(width_s), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_s_q.pop_front();
        chk("width_w4", 32'(width_s), e.width);
        chk("sat_w4", 32'(sat_s), 32'(e.sat));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("rst_valid", 32'(meas_valid), 0);
    chk("rst_width", 32'(meas_width), 0);
    chk("rst_sat", 32'(meas_sat), 0);
    chk("rst_busy", 32'(busy), 0);
`ifdef PWM_DROP_CNT_EN
    chk("rst_drop", 32'(drop_cnt), 0);
`endif
    step();
    rst_n = 1'b1;
    step();

    // basic: width 5, valid for exactly one cycle with ready high
    meas_ready = 1'b1;
    rise_pulse = 1'b1; step(); rise_pulse = 1'b0;
    chk("busy_after_rise", 32'(busy), 1);
    repeat (4) step();
    fall_pulse = 1'b1; exp_q.push_back('{32'd5, 1'b0}); step(); fall_pulse = 1'b0;
    chk("basic_valid", 32'(meas_valid), 1);
    step();
    chk("basic_valid_one_cycle", 32'(meas_valid), 0);
    chk("basic_idle", 32'(busy), 0);
    step();

    // minimum width
    rise_pulse = 1'b1; step(); rise_pulse = 1'b0;
    fall_pulse = 1'b1; exp_q.push_back('{32'd1, 1'b0}); step(); fall_pulse = 1'b0;
    step(); step();

    // simultaneous rise+fall in IDLE is ignored
    rise_pulse = 1'b1; fall_pulse = 1'b1; step();
    rise_pulse = 1'b0; fall_pulse = 1'b0;
    chk("both_busy", 32'(busy), 0);
    step();
    chk("both_valid", 32'(meas_valid), 0);

    // backpressure with two dropped pairs during HOLD
    meas_ready = 1'b0;
    rise_pulse = 1'b1; step(); rise_pulse = 1'b0;
    repeat (3) step();
    fall_pulse = 1'b1; exp_q.push_back('{32'd4, 1'b0}); step(); fall_pulse = 1'b0;
    chk("bp_valid", 32'(meas_valid), 1);
    for (int i = 0; i < 30; i++) begin
      rise_pulse = (i == 5 || i == 15);
      fall_pulse = (i == 8 || i == 20);
      step();
      chk("bp_width_held", 32'(meas_width), 4);
    end
    rise_pulse = 1'b0; fall_pulse = 1'b0;
    chk("bp_valid_held", 32'(meas_valid), 1);
`ifdef PWM_DROP_CNT_EN
    chk("bp_drop_cnt", 32'(drop_cnt), 2);
`endif
    meas_ready = 1'b1; step();
    chk("bp_after_valid", 32'(meas_valid), 0);
    chk("bp_after_busy", 32'(busy), 0);

    // handshake and rise in the same cycle, then width 7
    meas_ready = 1'b0;
    rise_pulse = 1'b1; step(); rise_pulse = 1'b0;
    repeat (2) step();
    fall_pulse = 1'b1; exp_q.push_back('{32'd3, 1'b0}); step(); fall_pulse = 1'b0;
    step(); step();
    meas_ready = 1'b1; rise_pulse = 1'b1; step(); rise_pulse = 1'b0;
    chk("hs_rise_busy", 32'(busy), 1);
    chk("hs_rise_valid", 32'(meas_valid), 0);
    repeat (6) step();
    fall_pulse = 1'b1; exp_q.push_back('{32'd7, 1'b0}); step(); fall_pulse = 1'b0;
    chk("hs_rise_valid2", 32'(meas_valid), 1);
    step();
    chk("hs_rise_done", 32'(meas_valid), 0);
`ifdef PWM_DROP_CNT_EN
    chk("hs_drop_unchanged", 32'(drop_cnt), 2);
`endif

    // CNT_W=4: saturation, exact all-ones, and one below
    rise_s = 1'b1; step(); rise_s = 1'b0;
    repeat (19) step();
    fall_s = 1'b1; exp_s_q.push_back('{32'd15, 1'b1}); step(); fall_s = 1'b0;
    step(); step();
    rise_s = 1'b1; step(); rise_s = 1'b0;
    repeat (14) step();
    fall_s = 1'b1; exp_s_q.push_back('{32'd15, 1'b0}); step(); fall_s = 1'b0;
    step(); step();
    rise_s = 1'b1; step(); rise_s = 1'b0;
    repeat (13) step();
    fall_s = 1'b1; exp_s_q.push_back('{32'd14, 1'b0}); step(); fall_s = 1'b0;
    step(); step();

    // async reset mid-MEASURE
    rise_pulse = 1'b1; step(); rise_pulse = 1'b0;
    repeat (3) step();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_valid", 32'(meas_valid), 0);
    chk("arst_width", 32'(meas_width), 0);
    chk("arst_sat", 32'(meas_sat), 0);
`ifdef PWM_DROP_CNT_EN
    chk("arst_drop", 32'(drop_cnt), 0);
`endif
    step();
    rst_n = 1'b1;
    step();
    fall_pulse = 1'b1; step(); fall_pulse = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("post_rst_busy", 32'(busy), 0);
      chk("post_rst_valid", 32'(meas_valid), 0);
      step();
    end

    for (int i = 0; i < 20 && (exp_q.size() != 0 || exp_s_q.size() != 0); i++) step();
    while (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("missing_result", 32'hFFFF_FFFF, e.width);
    end
    while (exp_s_q.size() != 0) begin
      exp_t e;
      e = exp_s_q.pop_front();
      chk("missing_result_w4", 32'hFFFF_FFFF, e.width);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
